// File: rtl/conv_pkg.sv
// Shared definitions for the convolutional stimulus generator: default code
// parameters, the frame FSM state type and the rate-1/2 parity function.
package conv_pkg;

  localparam int         KMAX    = 9;
  localparam int         K_DFLT  = 9;
  localparam logic [8:0] G0_DFLT = 9'o753;
  localparam logic [8:0] G1_DFLT = 9'o561;
  localparam int         WD_CODE = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } state_e;

  // Both generators are applied to the same window v = {d, sr}; bit 1 of the
  // symbol comes from g0 and bit 0 from g1. Unused upper bits must be zero.
  function automatic logic [WD_CODE-1:0] conv_sym(input logic [KMAX-1:0] v,
                                                  input logic [KMAX-1:0] g0,
                                                  input logic [KMAX-1:0] g1);
    conv_sym = {^(v & g0), ^(v & g1)};
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Rate-1/2 convolutional encoder core: K-1 bit shift register plus the two
// parity outputs for the current input bit.
module conv_enc_core #(
  parameter int         K  = conv_pkg::K_DFLT,
  parameter logic [8:0] G0 = conv_pkg::G0_DFLT,
  parameter logic [8:0] G1 = conv_pkg::G1_DFLT
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       clear,
  input  logic       advance,
  input  logic       d,
  output logic [1:0] sym
);
  import conv_pkg::*;

  logic [K-2:0]    sr_q, sr_d;
  logic [KMAX-1:0] win;
  logic [KMAX-1:0] g0_m;
  logic [KMAX-1:0] g1_m;

  // Next shift-register value: clear on frame start, shift newest bit in at the top on accept.
  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '0;
    end else if (advance) begin
      sr_d = {d, sr_q[K-2:1]};
    end
  end

  // Shift register state.
  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Parity window with the current input in bit K-1; generators trimmed to K taps.
  always_comb begin
    win          = '0;
    g0_m         = '0;
    g1_m         = '0;
    win[K-1:0]   = {d, sr_q};
    g0_m[K-1:0]  = G0[K-1:0];
    g1_m[K-1:0]  = G1[K-1:0];
    sym          = conv_sym(win, g0_m, g1_m);
  end

endmodule

// File: rtl/conv_stim_gen.sv
// Stimulus source for the Viterbi path: LFSR information bits, rate-1/2
// convolutional encoding with zero tail, and periodic channel-error injection.
module conv_stim_gen #(
  parameter int          K         = conv_pkg::K_DFLT,
  parameter logic [8:0]  G0        = conv_pkg::G0_DFLT,
  parameter logic [8:0]  G1        = conv_pkg::G1_DFLT,
  parameter int          WD_CODE   = conv_pkg::WD_CODE,
  parameter int          FRAME_LEN = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               CLOCK,
  input  logic               Reset,
  input  logic               Start,
  input  logic               ErrEn,
  input  logic [7:0]         ErrPeriod,
  input  logic [WD_CODE-1:0] ErrMask,
  input  logic               Ready,
  output logic               Valid,
  output logic [WD_CODE-1:0] Code,
  output logic [WD_CODE-1:0] CleanCode,
  output logic               DataBit,
  output logic               Busy,
  output logic               Done,
  output logic [15:0]        ErrCount
);
  import conv_pkg::*;

  localparam int TOTAL = FRAME_LEN + K - 1;
  localparam int CNT_W = $clog2(TOTAL + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         phase_q, phase_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        err_cnt_q, err_cnt_d;
  logic               err_en_q, err_en_d;
  logic [7:0]         err_per_q;
  logic [WD_CODE-1:0] err_mask_q;

  logic               active;
  logic               in_data;
  logic               start_ok;
  logic               accept;
  logic               inject;
  logic               last_data;
  logic               last_tail;
  logic               d_bit;
  logic [1:0]         enc_sym;

  assign active    = (state_q == DATA) || (state_q == TAIL);
  assign in_data   = (state_q == DATA);
  assign start_ok  = (state_q == IDLE) && Start;
  assign accept    = active && Ready;
  assign d_bit     = in_data & lfsr_q[0];
  assign last_data = (cnt_q == CNT_W'(FRAME_LEN - 1));
  assign last_tail = (cnt_q == CNT_W'(TOTAL - 1));
  // Injection depends only on registered phase and latched configuration.
  assign inject    = err_en_q && (err_per_q != 8'd0) && (phase_q == err_per_q - 8'd1);

  conv_enc_core #(
    .K  (K),
    .G0 (G0),
    .G1 (G1)
  ) u_enc (
    .CLOCK   (CLOCK),
    .Reset   (Reset),
    .clear   (start_ok),
    .advance (accept),
    .d       (d_bit),
    .sym     (enc_sym)
  );

  // Frame sequencing: data symbols, then K-1 tail symbols, then a single Done cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = DATA;
      DATA:    if (accept && last_data) state_d = TAIL;
      TAIL:    if (accept && last_tail) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Symbol/phase counters, LFSR advance and saturating injected-symbol count.
  always_comb begin
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    lfsr_d    = lfsr_q;
    err_cnt_d = err_cnt_q;
    err_en_d  = err_en_q;
    if (start_ok) begin
      cnt_d    = '0;
      phase_d  = 8'd0;
      err_en_d = ErrEn;
    end else if (accept) begin
      cnt_d   = cnt_q + CNT_W'(1);
      phase_d = (phase_q == err_per_q - 8'd1) ? 8'd0 : phase_q + 8'd1;
      if (in_data) begin
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      end
      if (inject && (err_mask_q != '0) && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  // Control state; the LFSR reseeds only here so frames continue the sequence.
  always_ff @(posedge CLOCK) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      phase_q   <= 8'd0;
      lfsr_q    <= LFSR_SEED;
      err_cnt_q <= 16'd0;
      err_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      lfsr_q    <= lfsr_d;
      err_cnt_q <= err_cnt_d;
      err_en_q  <= err_en_d;
    end
  end

  // Injection period and mask are captured at frame start and held for the frame.
  always_ff @(posedge CLOCK) begin
    if (start_ok) begin
      err_per_q  <= ErrPeriod;
      err_mask_q <= ErrMask;
    end
  end

  // Outputs decode registered state only, so nothing depends on Ready combinationally.
  always_comb begin
    Valid     = active;
    Busy      = active;
    Done      = (state_q == DONE);
    DataBit   = d_bit;
    CleanCode = active ? enc_sym : '0;
    Code      = CleanCode ^ ((active && inject) ? err_mask_q : '0);
    ErrCount  = err_cnt_q;
  end

endmodule
